// File: rtl/hazard_pkg.sv
// Shared constants for the RV32 hazard unit: forward-select encodings and
// default widths/latencies used by the scoreboard and its MDU tracker.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int MD_LAT_DEF = 4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_scoreboard_md_tracker.sv
// Tracks the single in-flight MDU operation: destination register and the
// countdown to its writeback strobe.
module md_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mdGo,
    input  logic [REG_AW-1:0] RdE,
    output logic              MdBusy,
    output logic [REG_AW-1:0] MdRd,
    output logic              MdWbValid,
    output logic              cntZero
);

    localparam int CNT_W = $clog2(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

    logic              mdBusy;
    logic [REG_AW-1:0] mdRd;
    logic [CNT_W-1:0]  mdCnt;
    logic              mdLoad;

    // An op targeting x0 produces nothing observable, so it is never tracked.
    assign mdLoad = mdGo && (RdE != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            mdBusy <= 1'b0;
            mdRd   <= '0;
            mdCnt  <= '0;
        end else if (mdLoad) begin
            mdBusy <= 1'b1;
            mdRd   <= RdE;
            mdCnt  <= CNT_LOAD;
        end else if (mdBusy) begin
            if (cntZero) begin
                mdBusy <= 1'b0;
            end else begin
                mdCnt <= mdCnt - CNT_W'(1);
            end
        end
    end

    assign cntZero   = (mdCnt == '0);
    assign MdBusy    = mdBusy;
    assign MdRd      = mdRd;
    assign MdWbValid = mdBusy && cntZero;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage RV32 pipeline: load-use and MDU scoreboard
// stalls, redirect/JAL flushes and M/W operand forwarding.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [1:0]        RegReadD,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              JalD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        RegReadE,
    input  logic              RegWriteE,
    input  logic              MemToRegE,
    input  logic              MulDivE,
    input  logic              BranchE,
    input  logic              JalrE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushF,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        Forward1E,
    output logic [1:0]        Forward2E,
    output logic              MdBusy,
    output logic              MdWbValid,
    output logic [REG_AW-1:0] MdRd
);

    logic mdGo;
    logic cntZero;
    logic loadUse;
    logic sbRaw;
    logic sbWaw;
    logic mdStruct;
    logic redirect;

    function automatic logic srcHit(input logic [REG_AW-1:0] r);
        return (r != '0) && ((RegReadD[1] && (Rs1D == r)) || (RegReadD[0] && (Rs2D == r)));
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs, input logic used);
        if (RegWriteM && (RdM != '0) && (RdM == rs) && used) return FWD_M;
        if (RegWriteW && (RdW != '0) && (RdW == rs) && used) return FWD_W;
        return FWD_RF;
    endfunction

    // The completion cycle still blocks D; the regfile holds the result one cycle later.
    assign loadUse  = MemToRegE && RegWriteE && srcHit(RdE);
    assign sbRaw    = (MdBusy && srcHit(MdRd)) || (MulDivE && srcHit(RdE));
    assign sbWaw    = MdBusy && RegWriteD && (RdD == MdRd) && (RdD != '0);
    assign mdStruct = MulDivE && MdBusy && !cntZero;
    assign redirect = BranchE || JalrE;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushF    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        Forward1E = FWD_RF;
        Forward2E = FWD_RF;
        if (rst) begin
            FlushF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else begin
            Forward1E = fwdSel(Rs1E, RegReadE[1]);
            Forward2E = fwdSel(Rs2E, RegReadE[0]);
            if (redirect) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (mdStruct) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (loadUse || sbRaw || sbWaw) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (JalD) begin
                FlushD = 1'b1;
            end
        end
    end

    assign mdGo = MulDivE && !StallE && !FlushE;

    md_tracker #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT)
    ) uMdTracker (
        .clk       (clk),
        .rst       (rst),
        .mdGo      (mdGo),
        .RdE       (RdE),
        .MdBusy    (MdBusy),
        .MdRd      (MdRd),
        .MdWbValid (MdWbValid),
        .cntZero   (cntZero)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MD_LAT=4): hand-computed stall, flush,
// forward and MDU-tracker expectations per cycle.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] RegReadD, RegReadE;
    logic       RegWriteD, JalD, RegWriteE, MemToRegE, MulDivE, BranchE, JalrE;
    logic       RegWriteM, RegWriteW;
    logic       StallF, StallD, StallE, StallM, StallW;
    logic       FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0] Forward1E, Forward2E;
    logic       MdBusy, MdWbValid;
    logic [4:0] MdRd;

    logic [4:0] stallVec, flushVec;
    assign stallVec = {StallF, StallD, StallE, StallM, StallW};
    assign flushVec = {FlushF, FlushD, FlushE, FlushM, FlushW};

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD), .RdD(RdD),
        .RegWriteD(RegWriteD), .JalD(JalD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegReadE(RegReadE),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MulDivE(MulDivE),
        .BranchE(BranchE), .JalrE(JalrE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E),
        .MdBusy(MdBusy), .MdWbValid(MdWbValid), .MdRd(MdRd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearInputs();
        Rs1D = 0; Rs2D = 0; RdD = 0; RegReadD = 0; RegWriteD = 0; JalD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; RegReadE = 0; RegWriteE = 0;
        MemToRegE = 0; MulDivE = 0; BranchE = 0; JalrE = 0;
        RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLoadUse();
        MemToRegE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10;
    endtask

    task automatic checkCtl(input string tag, input logic [4:0] expStall, input logic [4:0] expFlush);
        check({tag, ".stall"}, stallVec, expStall);
        check({tag, ".flush"}, flushVec, expFlush);
    endtask

    initial begin
        rst = 1;
        clearInputs();
        #1;
        check("rst.flush", flushVec, 5'b11111);
        check("rst.stall", stallVec, 5'b00000);
        check("rst.busy", MdBusy, 0);
        check("rst.wb", MdWbValid, 0);
        tick();
        tick();
        rst = 0;

        // Load-use through Rs1 and Rs2, then harmless variants.
        tick(); clearInputs(); setLoadUse(); #1;
        checkCtl("lu.rs1", 5'b11000, 5'b00100);
        tick(); clearInputs(); #1;
        checkCtl("lu.clear", 5'b00000, 5'b00000);
        tick(); setLoadUse(); RdE = 0; Rs1D = 0; #1;
        checkCtl("lu.x0", 5'b00000, 5'b00000);
        tick(); clearInputs(); setLoadUse(); Rs1D = 0; Rs2D = 5; RegReadD = 2'b01; #1;
        checkCtl("lu.rs2", 5'b11000, 5'b00100);
        tick(); RegReadD = 2'b10; #1;
        checkCtl("lu.unused", 5'b00000, 5'b00000);

        // Forwarding priority and x0 exclusion.
        tick(); clearInputs();
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; RegReadE = 2'b10; #1;
        check("fwd.m", Forward1E, 2'b10);
        check("fwd.m.op2", Forward2E, 2'b00);
        tick(); RegWriteM = 0; #1;
        check("fwd.w", Forward1E, 2'b01);
        tick(); RegWriteM = 1; RdM = 0; #1;
        check("fwd.m0", Forward1E, 2'b01);
        tick(); RdM = 7; Rs1E = 0; Rs2E = 7; RegReadE = 2'b01; #1;
        check("fwd2.m", Forward2E, 2'b10);
        check("fwd2.op1", Forward1E, 2'b00);
        tick(); RdW = 0; RdM = 0; #1;
        check("fwd2.none", Forward2E, 2'b00);

        // MDU op to x0 leaves the tracker idle.
        tick(); clearInputs(); MulDivE = 1; RegWriteE = 1; RdE = 0; #1;
        checkCtl("md0.issue", 5'b00000, 5'b00000);
        tick(); clearInputs(); #1;
        check("md0.busy", MdBusy, 0);
        check("md0.wb", MdWbValid, 0);

        // MDU latency: issue at t, D reads/writes x9 from t+1.
        tick(); clearInputs(); MulDivE = 1; RegWriteE = 1; RdE = 9; #1;
        checkCtl("lat.t", 5'b00000, 5'b00000);
        check("lat.t.busy", MdBusy, 0);
        for (int k = 1; k <= 5; k++) begin
            tick(); clearInputs();
            if (k == 2) begin
                RegWriteD = 1; RdD = 9;
            end else begin
                RegReadD = 2'b10; Rs1D = 9;
            end
            #1;
            check($sformatf("lat.t%0d.busy", k), MdBusy, (k <= 4));
            check($sformatf("lat.t%0d.wb", k), MdWbValid, (k == 4));
            if (k <= 4) begin
                check($sformatf("lat.t%0d.rd", k), MdRd, 9);
                checkCtl($sformatf("lat.t%0d", k), 5'b11000, 5'b00100);
            end else begin
                checkCtl($sformatf("lat.t%0d", k), 5'b00000, 5'b00000);
            end
        end

        // Structural hazard and back-to-back issue on the completion cycle.
        tick(); clearInputs(); MulDivE = 1; RegWriteE = 1; RdE = 9; #1;
        checkCtl("st.t", 5'b00000, 5'b00000);
        tick(); clearInputs(); #1;
        check("st.t1.busy", MdBusy, 1);
        for (int k = 2; k <= 9; k++) begin
            tick(); clearInputs();
            if (k <= 4) begin
                MulDivE = 1; RegWriteE = 1; RdE = 12;
            end
            #1;
            if (k <= 3)
                checkCtl($sformatf("st.t%0d", k), 5'b11100, 5'b00010);
            else
                checkCtl($sformatf("st.t%0d", k), 5'b00000, 5'b00000);
            check($sformatf("st.t%0d.wb", k), MdWbValid, (k == 4 || k == 8));
            check($sformatf("st.t%0d.busy", k), MdBusy, (k <= 8));
            if (k >= 5 && k <= 8) check($sformatf("st.t%0d.rd", k), MdRd, 12);
        end

        // Redirect outranks load-use; JalD yields to a stall.
        tick(); clearInputs(); setLoadUse(); BranchE = 1; #1;
        checkCtl("br.lu", 5'b00000, 5'b01100);
        tick(); clearInputs(); JalrE = 1; #1;
        checkCtl("jalr", 5'b00000, 5'b01100);
        tick(); clearInputs(); setLoadUse(); JalD = 1; #1;
        checkCtl("jal.lu", 5'b11000, 5'b00100);
        tick(); clearInputs(); JalD = 1; #1;
        checkCtl("jal", 5'b00000, 5'b01000);

        // Reset in the middle of an MDU op abandons it.
        tick(); clearInputs(); MulDivE = 1; RegWriteE = 1; RdE = 9; #1;
        tick(); clearInputs(); #1;
        check("rmid.t1.busy", MdBusy, 1);
        tick(); RdM = 3; RegWriteM = 1; Rs1E = 3; RegReadE = 2'b10; rst = 1; #1;
        check("rmid.busy", MdBusy, 0);
        check("rmid.wb", MdWbValid, 0);
        checkCtl("rmid", 5'b00000, 5'b11111);
        check("rmid.fwd", Forward1E, 2'b00);
        tick(); rst = 0; clearInputs();
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rpost%0d.wb", k), MdWbValid, 0);
            check($sformatf("rpost%0d.busy", k), MdBusy, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage RV32 pipeline (F/D/E/M/W).
- Adds a register scoreboard for one multi-cycle mul/div unit (MDU) of fixed latency, on top of the existing functions:
  - load-use stall
  - M/W forwarding
  - branch/jump flush
- Emits per-stage stall/flush, forward selects, and the MDU writeback strobe.
- Sits beside the pipeline registers; the only sequential state is the MDU tracker.

Parameters:
- REG_AW, 5: register index width; x0 is never a hazard source.
- MD_LAT, 4: MDU cycles from issue in E to writeback strobe; legal range 2..16.
- CNT_W, $clog2(MD_LAT): countdown width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_AW  D-stage sources
- RegReadD  in  2  [1]=uses Rs1D, [0]=uses Rs2D
- RdD  in  REG_AW  D-stage destination
- RegWriteD  in  1  D-stage instruction writes RdD
- JalD  in  1  JAL resolved in D
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage indices
- RegReadE  in  2  [1]=uses Rs1E, [0]=uses Rs2E
- RegWriteE  in  1  E-stage instruction writes RdE
- MemToRegE  in  1  E-stage is a load
- MulDivE  in  1  E-stage is an MDU op
- BranchE, JalrE  in  1  taken branch / JALR redirect in E
- RdM, RdW  in  REG_AW  destinations in M and W
- RegWriteM, RegWriteW  in  1  M/W write enables
- StallF, StallD, StallE, StallM, StallW  out  1
- FlushF, FlushD, FlushE, FlushM, FlushW  out  1
- Forward1E, Forward2E  out  2  00=regfile, 10=from M, 01=from W
- MdBusy  out  1  MDU holds an operation in flight
- MdWbValid  out  1  MDU result is written to MdRd this cycle
- MdRd  out  REG_AW  MDU destination

Behaviour:
- State: md_busy, md_rd[REG_AW-1:0], md_cnt[CNT_W-1:0].
- Async rst: state cleared to 0. While rst is high: all Flush*=1, all Stall*=0, Forward*=00, MdWbValid=0.
- Issue (md_go): MulDivE & ~StallE & ~FlushE.
  - Next state: md_busy=1, md_rd=RdE, md_cnt=MD_LAT-1.
- Countdown: while busy, md_cnt decrements each cycle.
- Completion: at md_cnt==0, MdWbValid=1 for exactly one cycle. Next cycle busy clears, unless a new md_go loads simultaneously (back-to-back issue allowed).
- MdBusy=md_busy; MdRd=md_rd. Neither MdBusy nor MdWbValid is set by an op with RdE==0.
- Hazard terms (combinational):
  - src_hit(r): (RegReadD[1]&&Rs1D==r) || (RegReadD[0]&&Rs2D==r), with r!=0.
  - load_use: MemToRegE & RegWriteE & src_hit(RdE).
  - sb_raw: (md_busy & src_hit(md_rd)) | (MulDivE & src_hit(RdE)). This includes the completion cycle; D releases the following cycle.
  - sb_waw: md_busy & RegWriteD & RdD==md_rd & RdD!=0.
  - md_struct: MulDivE & md_busy & ~(md_cnt==0).
  - redirect: BranchE | JalrE.
- Priority (highest first):
  - redirect: FlushD=1, FlushE=1. Stalls are suppressed, since D is killed.
  - md_struct: StallF=StallD=StallE=1, FlushM=1 (bubble into M).
  - load_use | sb_raw | sb_waw: StallF=StallD=1, FlushE=1.
  - JalD: FlushD=1, only when StallD=0.
- StallM, StallW, FlushF, FlushW: 0 except during reset.
- Forward1E (Forward2E identical using Rs2E/RegReadE[0]):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E & RegReadE[1].
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E & RegReadE[1].
  - Else 00.
  - Forwarding never selects the MDU result; the scoreboard stall guarantees a regfile read.
- Reset mid-operation: in-flight MDU op is abandoned; no MdWbValid after reset release.

Decomposition:
- Shared package (hazard_pkg):
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - REG_AW default.
- Sub-module md_tracker:
  - contains busy/rd/countdown registers.
  - inputs: md_go, RdE.
  - outputs: MdBusy, MdRd, MdWbValid, cnt_zero.
- Top level holds all combinational hazard/forward logic.

Test Plan:
- Load-use: MemToRegE=1, RegWriteE=1, RdE=5, Rs1D=5, RegReadD=10 -> StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 -> no stall.
- Forwarding: RdM=RdW=7, both writing, Rs1E=7 -> Forward1E=10. RegWriteM=0 -> 01. RdM=0 with RegWriteM=1 -> 01.
- MDU latency (MD_LAT=4): issue MulDivE with RdE=9 at cycle t -> MdBusy high t+1..t+4, MdWbValid=1 only at t+4, MdRd=9. D reading x9 is stalled through t+4 and released at t+5.
- Structural: second MulDivE at t+2 -> StallF/D/E=1 and FlushM=1 at t+2, t+3. Issue accepted at t+4 (cnt==0) -> new MdWbValid at t+8.
- Redirect priority: BranchE=1 with load_use true -> FlushD=FlushE=1, StallF=StallD=0. JalD=1 with load_use true -> FlushD=0.
- Reset mid-op: rst pulse at t+2 -> MdBusy=0 immediately, all Flush*=1; no MdWbValid after release.
